// File: rtl/morse_key_ctrl_if.sv
// ---------------------------------------------------------------------------
// morse_key_ctrl_if
// Purpose : bundles the keypad-scanner side and the character output side
//           of morse_key_ctrl.
// Signals :
//   key_valid  scanner strobe, key_code valid this cycle
//   key_code   4-bit hex keypad code
//   key_down   level, 1 while any key is held
//   scan_en    scanner enable from the controller
//   sym_valid  finished character available
//   sym_ready  downstream accepts the character
//   sym_bits   Morse elements, bit0 = first, 1 = dash, 0 = dot
//   sym_len    element count of sym_bits
// Handshake: a character transfers on every rising clk edge where
//   sym_valid && sym_ready. Once raised, sym_valid stays high and
//   sym_bits/sym_len stay stable until that transfer; the one exception
//   is mode = 1, which withdraws the character without a transfer.
// Modports: master = controller, slave = scanner/downstream/testbench.
// ---------------------------------------------------------------------------
interface morse_key_ctrl_if #(
  parameter int MAX_LEN = 5
);
  logic               key_valid;
  logic [3:0]         key_code;
  logic               key_down;
  logic               scan_en;
  logic               sym_valid;
  logic               sym_ready;
  logic [MAX_LEN-1:0] sym_bits;
  logic [2:0]         sym_len;

  modport master (
    input  key_valid, key_code, key_down, sym_ready,
    output scan_en, sym_valid, sym_bits, sym_len
  );

  modport slave (
    output key_valid, key_code, key_down, sym_ready,
    input  scan_en, sym_valid, sym_bits, sym_len
  );
endinterface

// File: rtl/morse_key_ctrl.sv
// ---------------------------------------------------------------------------
// morse_key_ctrl
// Purpose : sequencing controller between the 4x4 keypad scanner and the
//           Morse encode path. Accepts one key per physical press, builds
//           a dot/dash element buffer, supports backspace/clear, and hands
//           finished characters downstream on commit key or idle timeout.
// Ports   :
//   clk, rst_n    clock, asynchronous active-low reset
//   mode          1 = keypad owned elsewhere (held idle, input discarded)
//   bus           morse_key_ctrl_if.master (scanner + character handshake)
//   buf_len       current buffer fill, for display
//   err           one-cycle pulse on a rejected key
//   state_dbg_o   current FSM state (IDLE/WAIT_KEY/WAIT_RELEASE/EMIT)
// Key map : 1 = dot, 2 = dash, E = backspace, F = commit, C = clear;
//           any other code counts as a press with no effect.
// ---------------------------------------------------------------------------
module morse_key_ctrl #(
  parameter int MAX_LEN     = 5,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  morse_key_ctrl_if.master        bus,
  output logic [2:0]              buf_len,
  output logic                    err,
  output logic [1:0]              state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_KEY     = 2'd1,
    WAIT_RELEASE = 2'd2,
    EMIT         = 2'd3
  } state_e;

  localparam logic [3:0]       KEY_DOT    = 4'h1;
  localparam logic [3:0]       KEY_DASH   = 4'h2;
  localparam logic [3:0]       KEY_BS     = 4'hE;
  localparam logic [3:0]       KEY_COMMIT = 4'hF;
  localparam logic [3:0]       KEY_CLEAR  = 4'hC;
  localparam logic [2:0]       LEN_MAX    = 3'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_TERM   = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] buf_q, buf_d;
  logic [2:0]         len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] bits_q, bits_d;
  logic [2:0]         slen_q, slen_d;
  logic               auto_q, auto_d;    // current EMIT came from timeout
  logic               valid_q, valid_d;
  logic               scan_q, scan_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      slen_q  <= '0;
      auto_q  <= 1'b0;
      valid_q <= 1'b0;
      scan_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      slen_q  <= slen_d;
      auto_q  <= auto_d;
      valid_q <= valid_d;
      scan_q  <= scan_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    slen_d  = slen_q;
    auto_d  = auto_q;
    err_d   = 1'b0;

    if (mode) begin
      // Ownership handed away: drop everything, including a pending
      // character in EMIT.
      state_d = IDLE;
      buf_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_KEY;

        WAIT_KEY: begin
          if (bus.key_valid) begin
            // Any accepted key restarts the idle timer, even on the
            // terminal count.
            cnt_d   = '0;
            state_d = WAIT_RELEASE;
            case (bus.key_code)
              KEY_DOT, KEY_DASH: begin
                if (len_q == LEN_MAX) begin
                  err_d = 1'b1;
                end else begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                    if (3'(i) == len_q) buf_d[i] = (bus.key_code == KEY_DASH);
                  end
                  len_d = len_q + 3'd1;
                end
              end
              KEY_BS: begin
                if (len_q == 3'd0) begin
                  err_d = 1'b1;
                end else begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                    if (3'(i) == len_q - 3'd1) buf_d[i] = 1'b0;
                  end
                  len_d = len_q - 3'd1;
                end
              end
              KEY_CLEAR: begin
                buf_d = '0;
                len_d = '0;
              end
              KEY_COMMIT: begin
                if (len_q == 3'd0) begin
                  err_d = 1'b1;
                end else begin
                  bits_d  = buf_q;
                  slen_d  = len_q;
                  auto_d  = 1'b0;
                  state_d = EMIT;
                end
              end
              default: ;
            endcase
          end else if (len_q == 3'd0) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_TERM) begin
            bits_d  = buf_q;
            slen_d  = len_q;
            auto_d  = 1'b1;
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        WAIT_RELEASE: begin
          if (!bus.key_down) state_d = WAIT_KEY;
        end

        EMIT: begin
          // sym_valid is high for every EMIT cycle, so ready alone
          // completes the transfer.
          if (bus.sym_ready) begin
            buf_d   = '0;
            len_d   = '0;
            cnt_d   = '0;
            // A commit key is still physically held; a timeout is not.
            state_d = auto_q ? WAIT_KEY : WAIT_RELEASE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered, so they are derived from the next state.
    scan_d  = (state_d == WAIT_KEY) || (state_d == WAIT_RELEASE);
    valid_d = (state_d == EMIT);
  end

  assign bus.scan_en   = scan_q;
  assign bus.sym_valid = valid_q;
  assign bus.sym_bits  = bits_q;
  assign bus.sym_len   = slen_q;
  assign buf_len       = len_q;
  assign err           = err_q;
  assign state_dbg_o   = state_q;

endmodule
